ddr_write_packer: RTL and testbench

DDR_WRITE_PACKER -- requirements
Module: ddr_write_packer

---
 rtl/ddr_write_packer_pkg.sv | 24 ++
 rtl/ddr_write_packer_bitbuf.sv | 60 ++++++
 rtl/ddr_write_packer.sv | 89 ++++++++
 tb/tb_ddr_write_packer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/ddr_write_packer_pkg.sv
// Shared definitions for the DDR write packer: FSM encoding, default widths
// and the 64-word / 81-beat group ratio of the 324-bit to 256-bit repack.
package ddr_write_packer_pkg;

    localparam int DEF_DATA_IN_WIDTH = 324;
    localparam int DEF_DDR_WR_WIDTH  = 256;
    localparam int DEF_CNT_WIDTH     = 16;

    // 64 * 324 == 81 * 256: after each group of inputs the buffer drains to empty.
    localparam int GROUP_IN_WORDS    = 64;
    localparam int GROUP_OUT_BEATS   = 81;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic int fill_width(input int in_w, input int out_w);
        return $clog2(in_w + out_w + 1);
    endfunction

endpackage

// File: rtl/ddr_write_packer_bitbuf.sv
// LSB-first bit buffer: input words append above the current fill, output
// beats are taken from the bottom; both may happen in the same cycle.
module packer_bitbuf
    import ddr_write_packer_pkg::*;
#(
    parameter int IN_W   = DEF_DATA_IN_WIDTH,
    parameter int OUT_W  = DEF_DDR_WR_WIDTH,
    parameter int FILL_W = fill_width(DEF_DATA_IN_WIDTH, DEF_DDR_WR_WIDTH)
)(
    input  logic              clk,
    input  logic              srst,
    input  logic              i_in_fire,
    input  logic [IN_W-1:0]   i_in_data,
    input  logic              i_out_fire,
    output logic [OUT_W-1:0]  o_beat,
    output logic [FILL_W-1:0] o_fill
);

    localparam int BUF_W = IN_W + OUT_W;
    localparam logic [FILL_W-1:0] OUT_W_F = FILL_W'(OUT_W);
    localparam logic [FILL_W-1:0] IN_W_F  = FILL_W'(IN_W);

    logic [BUF_W-1:0]  r_buf;
    logic [FILL_W-1:0] r_fill;
    logic [BUF_W-1:0]  w_buf_shift;
    logic [BUF_W-1:0]  w_buf_next;
    logic [FILL_W-1:0] w_fill_shift;
    logic [FILL_W-1:0] w_fill_next;

    // Bits above the fill are always zero, so a residual beat is zero-padded
    // for free and removing it simply empties the buffer.
    always_comb begin
        w_buf_shift  = r_buf;
        w_fill_shift = r_fill;
        if (i_out_fire) begin
            w_buf_shift  = r_buf >> OUT_W;
            w_fill_shift = (r_fill >= OUT_W_F) ? (r_fill - OUT_W_F) : '0;
        end
        w_buf_next  = w_buf_shift;
        w_fill_next = w_fill_shift;
        if (i_in_fire) begin
            w_buf_next  = w_buf_shift | (BUF_W'(i_in_data) << w_fill_shift);
            w_fill_next = w_fill_shift + IN_W_F;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_buf  <= '0;
            r_fill <= '0;
        end else begin
            r_buf  <= w_buf_next;
            r_fill <= w_fill_next;
        end
    end

    assign o_beat = r_buf[OUT_W-1:0];
    assign o_fill = r_fill;

endmodule

// File: rtl/ddr_write_packer.sv
// Repacks a counted job of compute-array result words into DDR write beats,
// marking the final beat and pulsing done when the job has fully drained.
module ddr_write_packer
    import ddr_write_packer_pkg::*;
#(
    parameter int DATA_IN_WIDTH = DEF_DATA_IN_WIDTH,
    parameter int DDR_WR_WIDTH  = DEF_DDR_WR_WIDTH,
    parameter int CNT_WIDTH     = DEF_CNT_WIDTH
)(
    input  logic                     sys_clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [CNT_WIDTH-1:0]     word_cnt,
    input  logic [DATA_IN_WIDTH-1:0] res_data_in,
    input  logic                     res_valid_in,
    output logic                     res_ready_out,
    output logic [DDR_WR_WIDTH-1:0]  DDR_data_out,
    output logic                     DDR_valid_out,
    input  logic                     DDR_ready_in,
    output logic                     DDR_last_out,
    output logic                     busy,
    output logic                     done
);

    localparam int FILL_W = fill_width(DATA_IN_WIDTH, DDR_WR_WIDTH);
    localparam logic [FILL_W-1:0] BEAT_BITS = FILL_W'(DDR_WR_WIDTH);

    state_t                r_state;
    state_t                w_state_next;
    logic [CNT_WIDTH-1:0]  r_words_left;
    logic [FILL_W-1:0]     w_fill;
    logic [DDR_WR_WIDTH-1:0] w_beat;
    logic                  w_in_fire;
    logic                  w_out_fire;
    logic                  w_last_word;

    packer_bitbuf #(
        .IN_W   (DATA_IN_WIDTH),
        .OUT_W  (DDR_WR_WIDTH),
        .FILL_W (FILL_W)
    ) u_bitbuf (
        .clk        (sys_clk),
        .srst       (rst),
        .i_in_fire  (w_in_fire),
        .i_in_data  (res_data_in),
        .i_out_fire (w_out_fire),
        .o_beat     (w_beat),
        .o_fill     (w_fill)
    );

    // Accepting only at fill<=beat width keeps fill+word within the buffer.
    assign res_ready_out = (r_state == ST_RUN) && (r_words_left != '0) && (w_fill <= BEAT_BITS);
    assign DDR_valid_out = (w_fill >= BEAT_BITS) || ((r_state == ST_FLUSH) && (w_fill != '0));
    // In FLUSH no more input arrives, so the beat that empties the buffer is the last.
    assign DDR_last_out  = (r_state == ST_FLUSH) && (w_fill != '0) && (w_fill <= BEAT_BITS);
    assign DDR_data_out  = w_beat;
    assign busy          = (r_state == ST_RUN) || (r_state == ST_FLUSH);
    assign done          = (r_state == ST_DONE);

    assign w_in_fire   = res_valid_in && res_ready_out;
    assign w_out_fire  = DDR_valid_out && DDR_ready_in;
    assign w_last_word = w_in_fire && (r_words_left == CNT_WIDTH'(1));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_next = (word_cnt != '0) ? ST_RUN : ST_DONE;
            ST_RUN:   if (w_last_word) w_state_next = ST_FLUSH;
            ST_FLUSH: if (w_out_fire && DDR_last_out) w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_words_left <= '0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == ST_IDLE) && start) begin
                r_words_left <= word_cnt;
            end else if (w_in_fire) begin
                r_words_left <= r_words_left - CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_ddr_write_packer.sv
// Directed bench for ddr_write_packer: drives counted jobs and compares every
// beat against a bitstream model built from the words the bench sent.
module tb_ddr_write_packer;

    localparam int IN_W  = 324;
    localparam int OUT_W = 256;
    localparam int CNT_W = 16;

    logic             sys_clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] word_cnt = '0;
    logic [IN_W-1:0]  res_data_in = '0;
    logic             res_valid_in = 1'b0;
    logic             res_ready_out;
    logic [OUT_W-1:0] DDR_data_out;
    logic             DDR_valid_out;
    logic             DDR_ready_in = 1'b0;
    logic             DDR_last_out;
    logic             busy;
    logic             done;

    int tests_run = 0;
    int tests_failed = 0;

    logic [IN_W-1:0] words [0:127];

    ddr_write_packer #(
        .DATA_IN_WIDTH (IN_W),
        .DDR_WR_WIDTH  (OUT_W),
        .CNT_WIDTH     (CNT_W)
    ) dut (
        .sys_clk       (sys_clk),
        .rst           (rst),
        .start         (start),
        .word_cnt      (word_cnt),
        .res_data_in   (res_data_in),
        .res_valid_in  (res_valid_in),
        .res_ready_out (res_ready_out),
        .DDR_data_out  (DDR_data_out),
        .DDR_valid_out (DDR_valid_out),
        .DDR_ready_in  (DDR_ready_in),
        .DDR_last_out  (DDR_last_out),
        .busy          (busy),
        .done          (done)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check_eq(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Beat j of the job = stream bits [256j+255:256j], zero beyond the last word.
    function automatic logic [OUT_W-1:0] exp_beat(input int j, input int cnt);
        logic [OUT_W-1:0] r;
        int s;
        r = '0;
        for (int b = 0; b < OUT_W; b++) begin
            s = OUT_W * j + b;
            if (s / IN_W < cnt) r[b] = words[s / IN_W][s % IN_W];
        end
        return r;
    endfunction

    task automatic fill_words(input int cnt, input int mode);
        logic [351:0] tmp;
        for (int k = 0; k < cnt; k++) begin
            tmp = '0;
            for (int i = 0; i < 11; i++) begin
                case (mode)
                    0:       tmp[i*32 +: 32] = 32'(k * 16 + i);
                    1:       tmp[i*32 +: 32] = 32'hFFFF_FFFF;
                    default: tmp[i*32 +: 32] = $urandom();
                endcase
            end
            words[k] = tmp[IN_W-1:0];
        end
    endtask

    // mode: 0 ramp, 1 all ones, 2 random. abort_beats>=0 resets after that many beats.
    task automatic run_job(input int cnt, input int mode, input bit rnd_ready,
                           input int abort_beats, input int restart_at);
        int idx = 0, beats = 0, dones = 0, cyc = 0, valid_cycles = 0;
        int done_cyc = -1, first_in = -1, first_valid = -1;
        int exp_beats = (IN_W * cnt + OUT_W - 1) / OUT_W;
        bit in_f = 0, out_f = 0, stalled = 0, finished = 0;
        logic [OUT_W-1:0] held = '0;

        fill_words(cnt, mode);
        @(negedge sys_clk);
        start = 1'b1;
        word_cnt = CNT_W'(cnt);
        res_valid_in = 1'b0;
        DDR_ready_in = 1'b1;

        while (!finished && cyc < 3000) begin
            @(negedge sys_clk);
            if (abort_beats >= 0 && beats == abort_beats) begin
                start = 1'b0;
                res_valid_in = 1'b0;
                rst = 1'b1;
                @(posedge sys_clk);
                #1;
                check_eq("abort_ready", res_ready_out, 0);
                check_eq("abort_valid", DDR_valid_out, 0);
                check_eq("abort_last", DDR_last_out, 0);
                check_eq("abort_busy", busy, 0);
                check_eq("abort_done", done, 0);
                check_eq("abort_data", DDR_data_out, 0);
                @(negedge sys_clk);
                rst = 1'b0;
                $display("[TB] job cnt=%0d aborted after %0d beats", cnt, beats);
                return;
            end
            start = (cyc == restart_at);
            if (cyc == restart_at) word_cnt = CNT_W'(3);
            if (in_f) idx++;
            res_valid_in = (idx < cnt);
            res_data_in = (idx < cnt) ? words[idx] : '0;
            DDR_ready_in = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (cyc == 0) check_eq("busy_first", busy, (cnt > 0));
            if (stalled) begin
                check_eq("stall_valid", DDR_valid_out, 1);
                check_eq("stall_data", DDR_data_out, held);
            end
            if (DDR_valid_out) begin
                valid_cycles++;
                if (first_valid < 0) first_valid = cyc;
            end
            if (done) begin
                dones++;
                done_cyc = cyc;
                finished = 1;
                check_eq("done_after_beats", beats, exp_beats);
            end
            out_f = DDR_valid_out && DDR_ready_in;
            if (out_f) begin
                check_eq("beat_data", DDR_data_out, exp_beat(beats, cnt));
                check_eq("beat_last", DDR_last_out, (beats == exp_beats - 1));
                beats++;
            end
            stalled = DDR_valid_out && !DDR_ready_in;
            held = DDR_data_out;
            in_f = res_valid_in && res_ready_out;
            if (in_f && first_in < 0) first_in = cyc;
            cyc++;
        end
        check_eq("job_timeout", finished, 1);

        res_valid_in = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            #1;
            if (done) dones++;
            check_eq("idle_valid", DDR_valid_out, 0);
        end
        check_eq("beat_count", beats, exp_beats);
        check_eq("done_pulses", dones, 1);
        check_eq("words_taken", idx + (in_f ? 1 : 0), cnt);
        if (cnt == 0) begin
            check_eq("zero_done_lat", done_cyc, 0);
            check_eq("zero_no_valid", valid_cycles, 0);
        end else begin
            check_eq("first_beat_lat", first_valid, first_in + 1);
        end
        $display("[TB] job cnt=%0d mode=%0d rnd_ready=%0d beats=%0d done_cyc=%0d",
                 cnt, mode, rnd_ready, beats, done_cyc);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        check_eq("rst_ready", res_ready_out, 0);
        check_eq("rst_valid", DDR_valid_out, 0);
        check_eq("rst_last", DDR_last_out, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_data", DDR_data_out, 0);
        @(negedge sys_clk);
        rst = 1'b0;

        run_job(64, 0, 1'b0, -1, -1);
        run_job(1, 1, 1'b0, -1, -1);
        run_job(0, 0, 1'b0, -1, -1);
        run_job(64, 2, 1'b1, -1, -1);
        run_job(64, 0, 1'b0, 10, -1);
        run_job(2, 2, 1'b0, -1, -1);
        run_job(64, 0, 1'b0, -1, 20);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: got time %0t expected completion", $time);
        $fatal(1, "timeout");
    end

endmodule
